// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard mode timing sets, the {R, G, B} packing
// order of pixel words, and the raster total helpers.
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        h_pol: 1'b0,   v_pol: 1'b0
    };

    localparam vga_mode_t MODE_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
        h_pol: 1'b1,   v_pol: 1'b1
    };

    // Channel index within a pixel word; red occupies the most significant field.
    typedef enum int {
        CH_BLUE  = 0,
        CH_GREEN = 1,
        CH_RED   = 2
    } rgb_channel_t;

    // Per-position raster flags carried through the alignment delay.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_IDLE = '0;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int rgb_lsb(input rgb_channel_t ch, input int ch_bits);
        return int'(ch) * ch_bits;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a per-bit value;
// a depth of zero collapses to a straight wire.
module vga_delay_line #(
    parameter int               DEPTH       = 1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_shift
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_in;
            logic [WIDTH-1:0] stage_reg;

            if (gi == 0) begin : g_first
                assign stage_in = din;
            end else begin : g_chain
                assign stage_in = g_stage[gi-1].stage_reg;
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_reg <= RESET_VALUE;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end

        assign dout = g_stage[DEPTH-1].stage_reg;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y counters, sync/blank decode and an alignment
// delay so sync, blanking and returned colour leave the block together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = MODE_640X480_60.h_active,
    parameter int H_FP       = MODE_640X480_60.h_fp,
    parameter int H_SYNC     = MODE_640X480_60.h_sync,
    parameter int H_BP       = MODE_640X480_60.h_bp,
    parameter int V_ACTIVE   = MODE_640X480_60.v_active,
    parameter int V_FP       = MODE_640X480_60.v_fp,
    parameter int V_SYNC     = MODE_640X480_60.v_sync,
    parameter int V_BP       = MODE_640X480_60.v_bp,
    parameter bit H_POL      = MODE_640X480_60.h_pol,
    parameter bit V_POL      = MODE_640X480_60.v_pol,
    parameter int PIPE_DELAY = 0,
    parameter int CH_BITS    = 4,
    localparam int H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic                   clk25,
    input  logic                   reset,
    output logic [XW-1:0]          req_x,
    output logic [YW-1:0]          req_y,
    output logic                   req_valid,
    output logic                   line_start,
    output logic                   frame_start,
    input  logic [3*CH_BITS-1:0]   rgb_in,
    output logic [CH_BITS-1:0]     red_out,
    output logic [CH_BITS-1:0]     green_out,
    output logic [CH_BITS-1:0]     blue_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de_out
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 15 || CH_BITS < 1) begin : g_bad_params
        $error("vga_timing_gen: timing parameters must be >= 1 and PIPE_DELAY within 0..15");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam int R_LSB = rgb_lsb(CH_RED, CH_BITS);
    localparam int G_LSB = rgb_lsb(CH_GREEN, CH_BITS);
    localparam int B_LSB = rgb_lsb(CH_BLUE, CH_BITS);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    raster_flags_t raw_flags;
    raster_flags_t dly_flags;

    always_ff @(posedge clk25) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (x_reg == X_LAST) begin
            x_reg <= '0;
            y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
        end else begin
            x_reg <= x_reg + 1'b1;
        end
    end

    // Vertical sync spans whole lines, so it decodes from y alone.
    always_comb begin
        raw_flags     = FLAGS_IDLE;
        raw_flags.act = (x_reg < X_ACT) && (y_reg < Y_ACT);
        raw_flags.hs  = (x_reg >= HS_FIRST) && (x_reg <= HS_LAST);
        raw_flags.vs  = (y_reg >= VS_FIRST) && (y_reg <= VS_LAST);
    end

    assign req_x       = x_reg;
    assign req_y       = y_reg;
    assign req_valid   = raw_flags.act;
    assign line_start  = (x_reg == '0);
    assign frame_start = (x_reg == '0) && (y_reg == '0);

    vga_delay_line #(
        .DEPTH       (PIPE_DELAY),
        .WIDTH       ($bits(raster_flags_t)),
        .RESET_VALUE (FLAGS_IDLE)
    ) u_flag_delay (
        .clk  (clk25),
        .srst (reset),
        .din  (raw_flags),
        .dout (dly_flags)
    );

    // Final stage samples the upstream colour in the same edge the delayed
    // flags arrive, keeping colour, blanking and sync phase-aligned.
    always_ff @(posedge clk25) begin
        if (reset) begin
            de_out    <= 1'b0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
        end else begin
            de_out    <= dly_flags.act;
            red_out   <= dly_flags.act ? rgb_in[R_LSB +: CH_BITS] : '0;
            green_out <= dly_flags.act ? rgb_in[G_LSB +: CH_BITS] : '0;
            blue_out  <= dly_flags.act ? rgb_in[B_LSB +: CH_BITS] : '0;
            hsync     <= dly_flags.hs ~^ H_POL;
            vsync     <= dly_flags.vs ~^ V_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generator instances (tiny, small high-polarity, 640x480) under random
// colour data and random resets, checked every cycle against a raster model.
module tb_vga_timing_gen;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = '0;

    always #5 clk25 = ~clk25;

    // tiny mode: 4/1/2/1 x 3/1/1/1, no pipeline, active-low syncs
    logic [2:0] ax, ay;
    logic       arv, als, afs, ade, ahs, avs;
    logic [3:0] ar, ag, ab;
    // small mode: 10/2/3/2 x 6/1/2/2, PIPE_DELAY 3, active-high syncs
    logic [4:0] bx;
    logic [3:0] by;
    logic       brv, bls, bfs, bde, bhs, bvs;
    logic [3:0] br, bg, bb;
    // default 640x480 mode, PIPE_DELAY 3
    logic [9:0] cx, cy;
    logic       crv, cls, cfs, cde, chs, cvs;
    logic [3:0] cr, cg, cb;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(0), .CH_BITS(4)
    ) dut_a (
        .clk25(clk25), .reset(reset), .req_x(ax), .req_y(ay), .req_valid(arv),
        .line_start(als), .frame_start(afs), .rgb_in(rgb_in),
        .red_out(ar), .green_out(ag), .blue_out(ab),
        .hsync(ahs), .vsync(avs), .de_out(ade)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3), .CH_BITS(4)
    ) dut_b (
        .clk25(clk25), .reset(reset), .req_x(bx), .req_y(by), .req_valid(brv),
        .line_start(bls), .frame_start(bfs), .rgb_in(rgb_in),
        .red_out(br), .green_out(bg), .blue_out(bb),
        .hsync(bhs), .vsync(bvs), .de_out(bde)
    );

    vga_timing_gen #(
        .PIPE_DELAY(3)
    ) dut_c (
        .clk25(clk25), .reset(reset), .req_x(cx), .req_y(cy), .req_valid(crv),
        .line_start(cls), .frame_start(cfs), .rgb_in(rgb_in),
        .red_out(cr), .green_out(cg), .blue_out(cb),
        .hsync(chs), .vsync(cvs), .de_out(cde)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: k counts cycles since the last edge that saw reset high,
    // prev_rgb is the colour word captured at the edge starting this cycle.
    int          k        = 0;
    bit          valid    = 1'b0;
    logic [11:0] prev_rgb = '0;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h (cycle k=%0d)", what, act, exp, k);
        end
    endtask

    // Expected outputs follow directly from raster position arithmetic:
    // request at position k, aligned outputs describe position k-d-1.
    task automatic check_dut(input string nm,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input bit hp, input bit vp, input int d,
                             input logic [31:0] act_x, input logic [31:0] act_y,
                             input logic arv_i, input logic als_i, input logic afs_i,
                             input logic ade_i, input logic ahs_i, input logic avs_i,
                             input logic [11:0] argb);
        int ht, vt, x, y, m, xm, ym;
        logic e_rv, e_ls, e_fs, e_de, e_hs, e_vs;
        logic [11:0] e_rgb;
        logic [31:0] e_xy, a_xy;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        x     = k % ht;
        y     = (k / ht) % vt;
        e_rv  = (x < ha) && (y < va);
        e_ls  = (x == 0);
        e_fs  = (x == 0) && (y == 0);
        e_de  = 1'b0;
        e_hs  = ~hp;
        e_vs  = ~vp;
        e_rgb = '0;
        if (k >= d + 1) begin
            m    = k - d - 1;
            xm   = m % ht;
            ym   = (m / ht) % vt;
            e_de = (xm < ha) && (ym < va);
            e_hs = (xm >= ha + hf && xm < ha + hf + hs) ? hp : ~hp;
            e_vs = (ym >= va + vf && ym < va + vf + vs) ? vp : ~vp;
            e_rgb = e_de ? prev_rgb : 12'h000;
        end
        e_xy = {x[15:0], y[15:0]};
        a_xy = {act_x[15:0], act_y[15:0]};
        chk({nm, ".req_xy"}, a_xy, e_xy);
        chk({nm, ".req_flags"}, {29'b0, arv_i, als_i, afs_i}, {29'b0, e_rv, e_ls, e_fs});
        chk({nm, ".de_hs_vs"}, {29'b0, ade_i, ahs_i, avs_i}, {29'b0, e_de, e_hs, e_vs});
        chk({nm, ".rgb"}, {20'b0, argb}, {20'b0, e_rgb});
    endtask

    initial forever begin
        @(posedge clk25);
        prev_rgb = rgb_in;
        if (reset) begin
            k     = 0;
            valid = 1'b1;
        end else begin
            k = k + 1;
        end
    end

    initial forever begin
        @(posedge clk25);
        #1;
        rgb_in = 12'($urandom);
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk25);
        if (valid) begin
            check_dut("a", 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 0, 32'(ax), 32'(ay),
                      arv, als, afs, ade, ahs, avs, {ar, ag, ab});
            check_dut("b", 10, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1, 3, 32'(bx), 32'(by),
                      brv, bls, bfs, bde, bhs, bvs, {br, bg, bb});
            check_dut("c", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 3, 32'(cx), 32'(cy),
                      crv, cls, cfs, cde, chs, cvs, {cr, cg, cb});
        end
    end

    // Hand-computed per-frame / per-line totals that pin the model itself
    int a_last = 0, a_lline = 0, a_de = 0, a_hs = 0, a_vs = 0;
    int b_last = 0, b_de = 0, b_hs = 0, b_vs = 0;
    int c_lline = 0, c_de = 0, c_hs = 0;

    initial forever begin
        @(negedge clk25);
        if (valid) begin
            if (afs) begin
                if (k >= 96) begin
                    chk("a.frame_period", k - a_last, 48);
                    chk("a.de_per_frame", a_de, 12);
                    chk("a.hsync_low_per_frame", a_hs, 12);
                    chk("a.vsync_low_per_frame", a_vs, 8);
                end
                a_last = k; a_de = 0; a_hs = 0; a_vs = 0;
            end
            if (als) begin
                if (k >= 8) chk("a.line_period", k - a_lline, 8);
                a_lline = k;
            end
            a_de += (ade === 1'b1) ? 1 : 0;
            a_hs += (ahs === 1'b0) ? 1 : 0;
            a_vs += (avs === 1'b0) ? 1 : 0;

            if (bfs) begin
                if (k >= 374) begin
                    chk("b.frame_period", k - b_last, 187);
                    chk("b.de_per_frame", b_de, 60);
                    chk("b.hsync_high_per_frame", b_hs, 33);
                    chk("b.vsync_high_per_frame", b_vs, 34);
                end
                b_last = k; b_de = 0; b_hs = 0; b_vs = 0;
            end
            b_de += (bde === 1'b1) ? 1 : 0;
            b_hs += (bhs === 1'b1) ? 1 : 0;
            b_vs += (bvs === 1'b1) ? 1 : 0;

            if (cls) begin
                if (k >= 1600 && cy <= 10'd479) begin
                    chk("c.line_period", k - c_lline, 800);
                    chk("c.hsync_low_per_line", c_hs, 96);
                    chk("c.de_per_line", c_de, 640);
                end
                c_lline = k; c_de = 0; c_hs = 0;
            end
            c_de += (cde === 1'b1) ? 1 : 0;
            c_hs += (chs === 1'b0) ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    initial begin
        int found;
        int gap;
        int hold;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2000) tick();

        // Directed mid-frame reset on the small instance
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (bx == 5'd5 && by == 4'd4) found = 1;
            else tick();
        end
        chk("b.seek_position", found, 1);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b.rst_hsync_idle", {31'b0, bhs}, 0);
            chk("b.rst_vsync_idle", {31'b0, bvs}, 0);
            chk("a.rst_hsync_idle", {31'b0, ahs}, 1);
            chk("b.rst_de", {31'b0, bde}, 0);
            chk("b.rst_frame_start", {31'b0, bfs}, 1);
        end
        reset = 1'b0;
        chk("b.release_xy", {27'b0, bx}, 0);
        chk("b.release_y", {28'b0, by}, 0);
        chk("b.release_frame_start", {31'b0, bfs}, 1);
        chk("b.release_de_0", {31'b0, bde}, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("b.release_de_quiet", {31'b0, bde}, 0);
        end
        tick();
        chk("b.first_de_after_release", {31'b0, bde}, 1);
        chk("b.first_hsync_after_release", {31'b0, bhs}, 0);
        $display("txn directed reset: 5 cycles at b(x=5,y=4), checks=%0d", checks);

        for (int r = 0; r < 6; r++) begin
            gap  = int'($urandom_range(2000, 400));
            hold = int'($urandom_range(6, 1));
            repeat (gap) tick();
            reset = 1'b1;
            repeat (hold) tick();
            reset = 1'b0;
            $display("txn random reset %0d: run=%0d hold=%0d checks=%0d", r, gap, hold, checks);
        end

        repeat (2500) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
